fifo_stream_reader: RTL

- Read-side companion for the team's synchronous FIFO. It drives the FIFO's read port and absorbs the FIFO's one-cycle registered read latency.
- It presents the FIFO contents as a valid/ready stream to a downstream consumer at up to one word per cycle, with no data loss under arbitrary backpressure.
- Sits between the FIFO (r_en/data_out/empty) and any stream sink.

---
 rtl/fifo_stream_reader.sv | 89 ++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO: hides the one-cycle read latency behind a
// head + skid buffer and presents a valid/ready stream. Optional counter: FIFO_RD_STATS_EN.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_r_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_count
`endif
);

  logic             head_v_q, head_v_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             inflight_q;
  logic             pop;
  logic [2:0]       lvl;

  assign pop     = head_v_q & m_ready;
  assign m_valid = head_v_q;
  assign m_data  = head_q;

  // Committed words (buffered + inflight) after this cycle's pop; keep below 2 so
  // every word requested now has a guaranteed slot when it lands.
  assign lvl       = 3'(head_v_q) + 3'(skid_v_q) + 3'(inflight_q) - 3'(pop);
  assign fifo_r_en = !reset && !fifo_empty && (lvl < 3'd2);

  always_comb begin
    head_v_d = head_v_q;
    head_d   = head_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (pop) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        skid_v_d = inflight_q;
        if (inflight_q) skid_d = fifo_data;
      end else begin
        head_v_d = inflight_q;
        if (inflight_q) head_d = fifo_data;
      end
    end else if (inflight_q) begin
      if (!head_v_q) begin
        head_v_d = 1'b1;
        head_d   = fifo_data;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = fifo_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_v_q   <= 1'b0;
      head_q     <= '0;
      skid_v_q   <= 1'b0;
      skid_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      head_v_q   <= head_v_d;
      head_q     <= head_d;
      skid_v_q   <= skid_v_d;
      skid_q     <= skid_d;
      inflight_q <= fifo_r_en;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] cnt_q;
  assign xfer_count = cnt_q;

  always_ff @(posedge clk) begin
    if (reset)    cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + CNT_W'(1);
  end
`endif

endmodule
